wm_start_ctrl: RTL and testbench
================================

// Module: wm_start_ctrl
// PURPOSE
//  Front-panel start/interlock controller sitting directly upstream of the washing-machine FSM.
//  Debounces the raw START button and checks the door switch before the cycle can begin.
//  Locks the door, then issues the one-cycle srt pulse to the washer and holds the lock until
//  the washer's done plus a settle delay. Flags door-open faults and emits abort to reset the washer.
// PARAMETERS
//  DEB_CYC     4   consecutive cycles start_btn must be high (door closed) to accept a press
//  LOCK_CYC    2   cycles door_lock is asserted before srt is issued
//  UNLOCK_CYC  3   cycles door_lock is held after done before returning to IDLE
//  WDOG_CYC    40  RUN timeout in cycles (used only with WM_START_WDOG_EN)
//  CNT_W       6   shared phase counter width; must hold max(DEB_CYC,LOCK_CYC,UNLOCK_CYC,WDOG_CYC)
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst          in   1  asynchronous, active-high reset
//  start_btn    in   1  raw START push-button level (pre-synchronised)
//  door_closed  in   1  door switch, 1 = closed
//  done         in   1  washer done output (1-cycle high in washer Done state)
//  srt          out  1  registered start pulse to washer, exactly 1 cycle wide
//  door_lock    out  1  door solenoid drive, 1 = locked
//  run_led      out  1  high while in RUN
//  err          out  1  fault indicator, high while in ERR
//  abort        out  1  registered 1-cycle pulse on entry to ERR; OR'd into washer rst by the top level
// BEHAVIOUR
//  All outputs registered. Reset (any cycle, incl. mid-RUN): state=IDLE, cnt=0, all outputs 0.
//  States: IDLE, DEB, LOCK, RUN, UNLK, ERR (3-bit encoding); cnt clears on every state change.
//  IDLE: door_lock=0. start_btn & door_closed -> DEB.
//  DEB : !start_btn | !door_closed -> IDLE. Otherwise cnt++; at cnt==DEB_CYC-1 -> LOCK.
//        Net: button high for DEB_CYC consecutive DEB cycles; glitches shorter restart from IDLE.
//  LOCK: door_lock=1. !door_closed -> ERR. At cnt==LOCK_CYC-1 -> RUN, with srt=1 in the first RUN cycle.
//  RUN : door_lock=1, run_led=1; srt high only in its first cycle. Priority per cycle:
//        !door_closed -> ERR (wins over simultaneous done); else done -> UNLK.
//        start_btn ignored in RUN (no re-trigger, no second srt).
//  UNLK: door_lock=1, run_led=0. At cnt==UNLOCK_CYC-1 -> IDLE. start_btn and door_closed ignored.
//  ERR : err=1, door_lock=0; abort=1 in first ERR cycle only. Exit to IDLE when door_closed=1 &
//        start_btn=0 in the same cycle (operator must release button); held start does not re-arm.
//  Latency: button rise (door closed) -> srt high = 1 (IDLE->DEB) + DEB_CYC + LOCK_CYC cycles.
//  done arriving outside RUN is ignored. cnt saturates, never wraps. srt and abort never both high.
// CONFIGURATION
//  WM_START_WDOG_EN defined: in RUN, cnt counts RUN cycles; reaching cnt==WDOG_CYC-1 without done
//   -> ERR (abort pulse, err=1), same exit rule as door fault. done in that same cycle wins -> UNLK.
//  Not defined: no timeout; RUN waits for done indefinitely; WDOG_CYC unused; no extra logic.
// TESTING
//  T1 rst mid-RUN (door_lock=1) -> next cycle all outputs 0, state IDLE; release rst, no srt w/o new press.
//  T2 door closed, start_btn high 10 cycles -> srt 1-cycle pulse exactly 7 cycles after button rise,
//     door_lock high from cycle 5; only one srt despite button held.
//  T3 start_btn high 3 cycles, low 1, high 2 -> no srt, door_lock stays 0 throughout.
//  T4 normal run: done pulse in RUN -> run_led drops next cycle, door_lock stays 1 for 3 cycles, then 0.
//  T5 door_closed drops in RUN (same cycle as done) -> ERR: abort 1 cycle, err=1, door_lock=0;
//     start_btn=0 & door closed -> IDLE next cycle, err=0.
//  T6 WM_START_WDOG_EN, no done for 40 RUN cycles -> abort pulse, err=1; without macro -> remains in RUN.

Source files
------------

// File: rtl/wm_start_if.sv
// Start/interlock handshake bundle between the front panel/washer and wm_start_ctrl.
// master: controller side (drives srt/door_lock/run_led/err/abort); slave: panel/washer side.
interface wm_start_if;
  logic start_btn;
  logic door_closed;
  logic done;
  logic srt;
  logic door_lock;
  logic run_led;
  logic err;
  logic abort;

  modport master (
    input  start_btn,
    input  door_closed,
    input  done,
    output srt,
    output door_lock,
    output run_led,
    output err,
    output abort
  );

  modport slave (
    output start_btn,
    output door_closed,
    output done,
    input  srt,
    input  door_lock,
    input  run_led,
    input  err,
    input  abort
  );
endinterface

// File: rtl/wm_start_ctrl.sv
// Washer start/interlock controller: debounces START, locks the door, pulses srt,
// holds the lock until done plus a settle delay, and raises err/abort on door faults.
// Ports: clk, rst (async, active high), bus (wm_start_if.master):
//   in  start_btn, door_closed, done; out srt, door_lock, run_led, err, abort.
// Optional: define WM_START_WDOG_EN for a RUN timeout of WDOG_CYC cycles.
module wm_start_ctrl #(
  parameter int DEB_CYC    = 4,
  parameter int LOCK_CYC   = 2,
  parameter int UNLOCK_CYC = 3,
  parameter int WDOG_CYC   = 40,
  parameter int CNT_W      = 6
) (
  input  logic          clk,
  input  logic          rst,
  wm_start_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEB  = 3'd1,
    S_LOCK = 3'd2,
    S_RUN  = 3'd3,
    S_UNLK = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int M1 = (DEB_CYC > LOCK_CYC) ? DEB_CYC : LOCK_CYC;
  localparam int M2 = (M1 > UNLOCK_CYC) ? M1 : UNLOCK_CYC;
  localparam int MX = (M2 > WDOG_CYC) ? M2 : WDOG_CYC;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] UNLK_LAST = CNT_W'(UNLOCK_CYC - 1);
  // Counter stops at the longest phase length instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MX);
`ifdef WM_START_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
`endif

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             srt_q;
  logic             lock_q;
  logic             led_q;
  logic             err_q;
  logic             abort_q;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start_btn && bus.door_closed)
          nxt = S_DEB;
      end
      S_DEB: begin
        if (!bus.start_btn || !bus.door_closed)
          nxt = S_IDLE;
        else if (cnt == DEB_LAST)
          nxt = S_LOCK;
      end
      S_LOCK: begin
        if (!bus.door_closed)
          nxt = S_ERR;
        else if (cnt == LOCK_LAST)
          nxt = S_RUN;
      end
      S_RUN: begin
        // Door fault beats done; done beats timeout.
        if (!bus.door_closed)
          nxt = S_ERR;
        else if (bus.done)
          nxt = S_UNLK;
`ifdef WM_START_WDOG_EN
        else if (cnt == WDOG_LAST)
          nxt = S_ERR;
`endif
      end
      S_UNLK: begin
        if (cnt == UNLK_LAST)
          nxt = S_IDLE;
      end
      S_ERR: begin
        // Require button release so a held START cannot re-arm.
        if (bus.door_closed && !bus.start_btn)
          nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      srt_q   <= 1'b0;
      lock_q  <= 1'b0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (cnt != CNT_SAT)
        cnt <= cnt + 1'b1;
      srt_q   <= (nxt == S_RUN) && (state != S_RUN);
      abort_q <= (nxt == S_ERR) && (state != S_ERR);
      lock_q  <= (nxt == S_LOCK) || (nxt == S_RUN) ||
                 (nxt == S_UNLK);
      led_q   <= (nxt == S_RUN);
      err_q   <= (nxt == S_ERR);
    end
  end

  assign bus.srt       = srt_q;
  assign bus.door_lock = lock_q;
  assign bus.run_led   = led_q;
  assign bus.err       = err_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_wm_start_ctrl.sv
// Testbench for wm_start_ctrl: directed scenarios plus randomized panel activity
// checked against a cycle-level behavioural model of the start/interlock rules.
module tb_wm_start_ctrl;

  localparam int DEB_CYC    = 4;
  localparam int LOCK_CYC   = 2;
  localparam int UNLOCK_CYC = 3;
  localparam int WDOG_CYC   = 40;
  localparam int CNT_W      = 6;

`ifdef WM_START_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_DEB  = 1;
  localparam int M_LOCK = 2;
  localparam int M_RUN  = 3;
  localparam int M_UNLK = 4;
  localparam int M_ERR  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wm_start_if bus ();

  wm_start_ctrl #(
    .DEB_CYC    (DEB_CYC),
    .LOCK_CYC   (LOCK_CYC),
    .UNLOCK_CYC (UNLOCK_CYC),
    .WDOG_CYC   (WDOG_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_mode = M_IDLE;
  int m_age  = 0;
  logic e_srt, e_lock, e_led, e_err, e_abort;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_age   = 0;
    e_srt   = 1'b0;
    e_lock  = 1'b0;
    e_led   = 1'b0;
    e_err   = 1'b0;
    e_abort = 1'b0;
  endtask

  // One clock of the panel rules, applied to the inputs seen at the edge.
  task automatic model_step();
    int nm;
    logic b, d, dn;
    b  = bus.start_btn;
    d  = bus.door_closed;
    dn = bus.done;
    nm = m_mode;
    if (m_mode == M_IDLE) begin
      if (b && d) nm = M_DEB;
    end else if (m_mode == M_DEB) begin
      if (!(b && d)) nm = M_IDLE;
      else if (m_age + 1 == DEB_CYC) nm = M_LOCK;
    end else if (m_mode == M_LOCK) begin
      if (!d) nm = M_ERR;
      else if (m_age + 1 == LOCK_CYC) nm = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!d) nm = M_ERR;
      else if (dn) nm = M_UNLK;
      else if (WDOG && m_age + 1 == WDOG_CYC) nm = M_ERR;
    end else if (m_mode == M_UNLK) begin
      if (m_age + 1 == UNLOCK_CYC) nm = M_IDLE;
    end else begin
      if (d && !b) nm = M_IDLE;
    end
    e_srt   = (nm == M_RUN) && (m_mode != M_RUN);
    e_abort = (nm == M_ERR) && (m_mode != M_ERR);
    e_lock  = (nm == M_LOCK) || (nm == M_RUN) || (nm == M_UNLK);
    e_led   = (nm == M_RUN);
    e_err   = (nm == M_ERR);
    m_age   = (nm == m_mode) ? m_age + 1 : 0;
    m_mode  = nm;
  endtask

  task automatic chk_all(input string ph);
    chk({ph, ".srt"},   bus.srt,       e_srt);
    chk({ph, ".lock"},  bus.door_lock, e_lock);
    chk({ph, ".led"},   bus.run_led,   e_led);
    chk({ph, ".err"},   bus.err,       e_err);
    chk({ph, ".abort"}, bus.abort,     e_abort);
  endtask

  string phase = "init";

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk_all(phase);
  endtask

  task automatic go_run();
    bus.start_btn = 1'b1;
    repeat (1 + DEB_CYC + LOCK_CYC) step();
    bus.start_btn = 1'b0;
  endtask

  initial begin
    int srt_cnt, srt_at, lock_at, lock_len, ab_cnt;
    bus.start_btn   = 1'b0;
    bus.door_closed = 1'b1;
    bus.done        = 1'b0;
    model_reset();

    phase = "reset";
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // T2: held button, latency and single srt
    phase = "t2";
    srt_cnt = 0; srt_at = -1; lock_at = -1;
    bus.start_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.srt) begin srt_cnt++; srt_at = i; end
      if (bus.door_lock && lock_at < 0) lock_at = i;
    end
    bus.start_btn = 1'b0;
    chk_int("t2_srt_cycle", srt_at, 7);
    chk_int("t2_srt_count", srt_cnt, 1);
    chk_int("t2_lock_cycle", lock_at, 5);

    // T4: done in RUN, settle then unlock
    phase = "t4";
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("t4_led_drop", bus.run_led, 1'b0);
    lock_len = bus.door_lock ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.door_lock) lock_len++;
    end
    chk_int("t4_lock_len", lock_len, 3);

    // T3: glitchy button never accepted
    phase = "t3";
    lock_at = 0; srt_cnt = 0;
    bus.start_btn = 1'b1;
    repeat (3) begin
      step();
      lock_at += bus.door_lock; srt_cnt += bus.srt;
    end
    bus.start_btn = 1'b0;
    step();
    bus.start_btn = 1'b1;
    repeat (2) begin
      step();
      lock_at += bus.door_lock; srt_cnt += bus.srt;
    end
    bus.start_btn = 1'b0;
    repeat (6) begin
      step();
      lock_at += bus.door_lock; srt_cnt += bus.srt;
    end
    chk_int("t3_lock_cycles", lock_at, 0);
    chk_int("t3_srt_count", srt_cnt, 0);

    // T5: door opens together with done in RUN
    phase = "t5";
    go_run();
    step();
    bus.door_closed = 1'b0;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("t5_abort", bus.abort, 1'b1);
    chk("t5_err", bus.err, 1'b1);
    chk("t5_lock", bus.door_lock, 1'b0);
    step();
    chk("t5_abort_once", bus.abort, 1'b0);
    bus.door_closed = 1'b1;
    bus.start_btn = 1'b1;
    step();
    chk("t5_held_btn", bus.err, 1'b1);
    bus.start_btn = 1'b0;
    step();
    chk("t5_exit", bus.err, 1'b0);
    step();

    // T6: RUN without done
    phase = "t6";
    go_run();
    ab_cnt = 0;
    repeat (WDOG_CYC + 5) begin
      step();
      ab_cnt += bus.abort;
    end
    chk_int("t6_abort_count", ab_cnt, WDOG ? 1 : 0);
    chk("t6_err", bus.err, WDOG);
    chk("t6_led", bus.run_led, !WDOG);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    repeat (6) step();

    // T1: async reset in the middle of RUN
    phase = "t1";
    go_run();
    step();
    chk("t1_locked", bus.door_lock, 1'b1);
    rst = 1'b1;
    #2;
    model_reset();
    chk_all("t1_async");
    step();
    rst = 1'b0;
    srt_cnt = 0;
    repeat (12) begin
      step();
      srt_cnt += bus.srt;
    end
    chk_int("t1_no_srt", srt_cnt, 0);

    // Randomized panel activity
    phase = "rand";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)
        bus.start_btn = ~bus.start_btn;
      if (bus.door_closed) begin
        if ($urandom_range(79) == 0) bus.door_closed = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.door_closed = 1'b1;
      end
      bus.done = ($urandom_range(24) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
